spi_mem_responder: RTL

- SPI slave (mode 0, MSB first) that answers the SPI master in the byte-collector block and stores the bytes it is sent.
- Holds a byte-addressed internal memory. Supports WRITE (0x02) and READ (0x03) commands with an 8-bit start address and address auto-increment.
- All logic is clocked by Mclk. The SPI pins are treated as asynchronous inputs and oversampled.
- Used as the far-end memory model in system simulation and as a synthesizable loop-back target on the board.

---
 rtl/spi_mem_pkg.sv | 21 ++
 rtl/spi_mem_responder_spi_in_sync.sv | 42 ++++
 rtl/spi_mem_responder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI memory responder: command codes, FSM states
// and the default address width.
package spi_mem_pkg;

  localparam int DEF_ADDR_W = 8;

  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_STATUS = 8'h05;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WR,
    RD,
    IGNORE,
    STAT
  } state_t;

endpackage

// File: rtl/spi_mem_responder_spi_in_sync.sv
// Synchronizes the asynchronous SPI pins into the Mclk domain and turns the
// synchronized SPI clock into single-cycle rise/fall pulses.
module spi_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_n_s,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_p0;

  // CS resets to its inactive (high) level so no false select appears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_p0   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_p0   <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_p0;
  assign sclk_fall = ~sclk_sync[SYNC_STAGES-1] & sclk_p0;
  assign cs_n_s    = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 slave with a byte-addressed memory: WRITE 0x02 / READ 0x03 with
// auto-incrementing address. Define SPI_STATUS_CMD_EN to add status command 0x05.
module spi_mem_responder
  import spi_mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              Mclk,
  input  logic              nReset,
  input  logic              SPI_clk,
  input  logic              SPI_CS,
  input  logic              SPI_MOSI,
  output logic              SPI_MISO,
  output logic              Wr_Strobe,
  output logic [ADDR_W-1:0] Wr_Addr,
  output logic [7:0]        Wr_Data,
  output logic              Busy,
  output logic              Cmd_Err
);

  localparam int DEPTH = 1 << ADDR_W;

  logic              sclk_rise;
  logic              sclk_fall;
  logic              cs_n_s;
  logic              mosi_s;
  state_t            state;
  logic [2:0]        bit_cnt;
  logic [6:0]        shreg;
  logic [ADDR_W-1:0] ptr;
  logic              is_rd;
  logic [7:0]        rx_byte;
  logic [7:0]        rd_byte;
  logic              byte_done;
  logic              mem_we;
  logic [7:0]        mem [DEPTH];

  spi_in_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (Mclk),
    .rst_n    (nReset),
    .sclk     (SPI_clk),
    .cs_n     (SPI_CS),
    .mosi     (SPI_MOSI),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall),
    .cs_n_s   (cs_n_s),
    .mosi_s   (mosi_s)
  );

  assign rx_byte   = {shreg, mosi_s};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7);
  assign mem_we    = (state == WR) && byte_done && !cs_n_s;
  assign rd_byte   = mem[ptr];

  always_ff @(posedge Mclk) begin
    if (mem_we) mem[ptr] <= rx_byte;
  end

`ifdef SPI_STATUS_CMD_EN
  logic [6:0] wr_count;
  logic       err_sticky;
  logic [7:0] status_byte;

  assign status_byte = {err_sticky, wr_count};

  always_ff @(posedge Mclk or negedge nReset) begin
    if (!nReset) begin
      wr_count   <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (mem_we && wr_count != 7'h7F) wr_count <= wr_count + 7'd1;
      if (Cmd_Err) err_sticky <= 1'b1;
    end
  end
`endif

  always_ff @(posedge Mclk or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      SPI_MISO  <= 1'b0;
      Wr_Strobe <= 1'b0;
      Wr_Addr   <= '0;
      Wr_Data   <= '0;
      Busy      <= 1'b0;
      Cmd_Err   <= 1'b0;
      bit_cnt   <= '0;
      shreg     <= '0;
      ptr       <= '0;
      is_rd     <= 1'b0;
    end else begin
      Wr_Strobe <= 1'b0;
      Cmd_Err   <= 1'b0;
      // A deselect outranks any byte completing in the same cycle.
      if (state != IDLE && cs_n_s) begin
        state    <= IDLE;
        Busy     <= 1'b0;
        SPI_MISO <= 1'b0;
        bit_cnt  <= '0;
      end else begin
        if (sclk_rise && state != IDLE) begin
          shreg   <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
        end
        case (state)
          IDLE: begin
            SPI_MISO <= 1'b0;
            if (!cs_n_s) begin
              state <= CMD;
              Busy  <= 1'b1;
            end
          end
          CMD: begin
            SPI_MISO <= 1'b0;
            if (byte_done) begin
              if (rx_byte == CMD_WRITE || rx_byte == CMD_READ) begin
                is_rd <= (rx_byte == CMD_READ);
                state <= ADDR;
`ifdef SPI_STATUS_CMD_EN
              end else if (rx_byte == CMD_STATUS) begin
                state <= STAT;
`endif
              end else begin
                state   <= IGNORE;
                Cmd_Err <= 1'b1;
              end
            end
          end
          ADDR: begin
            SPI_MISO <= 1'b0;
            if (byte_done) begin
              ptr   <= ADDR_W'(rx_byte);
              state <= is_rd ? RD : WR;
            end
          end
          WR: begin
            SPI_MISO <= 1'b0;
            if (byte_done) begin
              Wr_Strobe <= 1'b1;
              Wr_Addr   <= ptr;
              Wr_Data   <= rx_byte;
              ptr       <= ptr + 1'b1;
            end
          end
          // The bit counter doubles as the output bit index: count 0 presents bit 7.
          RD: begin
            if (sclk_fall) SPI_MISO <= rd_byte[~bit_cnt];
            if (byte_done) ptr <= ptr + 1'b1;
          end
`ifdef SPI_STATUS_CMD_EN
          STAT: begin
            if (sclk_fall) SPI_MISO <= status_byte[~bit_cnt];
          end
`endif
          default: SPI_MISO <= 1'b0;
        endcase
      end
    end
  end

endmodule
